// File: rtl/rv_predecode_buffer.sv
// rv_predecode_buffer: instruction FIFO between fetch and decode with static
// BTFN/JAL pre-decode. Predicted-taken pushes raise a one-cycle registered
// fetch redirect. Fetch-side offers made during that redirect cycle are on the
// wrong path and are dropped.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. f_ready_o depends only on the fill level, never on f_valid_i. d_valid_o
// depends only on the fill level, never on cu_stall_i. The head stays stable
// until it is popped or killed.
module rv_predecode_buffer #(
  parameter int XLEN         = 32,
  parameter int ILEN         = 32,
  parameter int DEPTH        = 4,
  parameter int PREDICT_MODE = 1
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       cu_kill_i,
  input  logic                       cu_stall_i,
  input  logic [ILEN-1:0]            f_instr_i,
  input  logic [XLEN-1:0]            f_current_pc_i,
  input  logic [XLEN-1:0]            f_next_pc_i,
  input  logic                       f_valid_i,
  output logic                       f_ready_o,
  output logic                       d_valid_o,
  output logic [ILEN-1:0]            d_instr_o,
  output logic [XLEN-1:0]            d_current_pc_o,
  output logic [XLEN-1:0]            d_next_pc_o,
  output logic                       d_prediction_o,
  output logic                       pred_redirect_o,
  output logic [XLEN-1:0]            pred_target_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Entry storage. Contents are only observed through the level, so the
  // storage is not reset.
  logic [ILEN-1:0] r_instr   [DEPTH];
  logic [XLEN-1:0] r_pc      [DEPTH];
  logic [XLEN-1:0] r_next_pc [DEPTH];
  logic            r_pred    [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_redirect;
  logic [XLEN-1:0] r_target;

  logic            w_push;
  logic            w_pop;
  logic            w_mode;
  logic [6:0]      w_opcode;
  logic            w_is_bwd_branch;
  logic            w_is_jal;
  logic            w_pred;
  logic [12:0]     w_imm_b13;
  logic [20:0]     w_imm_j21;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_target;

  assign f_ready_o = (r_level != LW'(DEPTH));
  assign d_valid_o = (r_level != '0);

  // A redirect cycle blocks pushes: that offer came from the old fetch path.
  assign w_push = f_valid_i & f_ready_o & ~cu_kill_i & ~r_redirect;
  assign w_pop  = d_valid_o & ~cu_stall_i & ~cu_kill_i;

  // Static pre-decode of the incoming instruction.
  always_comb begin
    w_mode          = (PREDICT_MODE != 0);
    w_opcode        = f_instr_i[6:0];
    w_imm_b13       = {f_instr_i[31], f_instr_i[7], f_instr_i[30:25],
                       f_instr_i[11:8], 1'b0};
    w_imm_j21       = {f_instr_i[31], f_instr_i[19:12], f_instr_i[20],
                       f_instr_i[30:21], 1'b0};
    w_imm_b         = {{(XLEN-13){w_imm_b13[12]}}, w_imm_b13};
    w_imm_j         = {{(XLEN-21){w_imm_j21[20]}}, w_imm_j21};
    // A sign bit of 1 means a negative offset, so the branch goes backward.
    w_is_bwd_branch = (w_opcode == OPC_BRANCH) & f_instr_i[31];
    w_is_jal        = (w_opcode == OPC_JAL);
    w_pred          = w_mode & (w_is_bwd_branch | w_is_jal);
    w_target        = f_current_pc_i + (w_is_jal ? w_imm_j : w_imm_b);
  end

  // FIFO pointers and fill level. A kill empties the buffer.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (cu_kill_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry write on push.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr[r_wr_ptr]   <= f_instr_i;
      r_pc[r_wr_ptr]      <= f_current_pc_i;
      r_next_pc[r_wr_ptr] <= f_next_pc_i;
      r_pred[r_wr_ptr]    <= w_pred;
    end
  end

  // Registered one-cycle redirect pulse. A kill cancels a pending redirect.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_redirect <= 1'b0;
      r_target   <= '0;
    end else begin
      r_redirect <= w_push & w_pred & ~cu_kill_i;
      if (w_push & w_pred) r_target <= w_target;
    end
  end

  assign d_instr_o       = r_instr[r_rd_ptr];
  assign d_current_pc_o  = r_pc[r_rd_ptr];
  assign d_next_pc_o     = r_next_pc[r_rd_ptr];
  assign d_prediction_o  = r_pred[r_rd_ptr];
  assign pred_redirect_o = r_redirect;
  assign pred_target_o   = r_target;
  assign level_o         = r_level;

endmodule

// File: tb/tb_rv_predecode_buffer.sv
// Directed bench for rv_predecode_buffer. The inst_p instance uses BTFN
// prediction and the inst_n instance has prediction disabled. Both instances
// share the same stimulus.
module tb_rv_predecode_buffer;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic            cu_kill, cu_stall, f_valid;
  logic [ILEN-1:0] f_instr;
  logic [XLEN-1:0] f_pc, f_npc;

  logic            p_ready, p_dvalid, p_pred, p_redir;
  logic [ILEN-1:0] p_instr;
  logic [XLEN-1:0] p_pc, p_npc, p_target;
  logic [LW-1:0]   p_level;

  logic            n_ready, n_dvalid, n_pred, n_redir;
  logic [ILEN-1:0] n_instr;
  logic [XLEN-1:0] n_pc, n_npc, n_target;
  logic [LW-1:0]   n_level;

  rv_predecode_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .PREDICT_MODE(1)) inst_p (
    .clk_i(clk), .arstn_i(arstn), .cu_kill_i(cu_kill), .cu_stall_i(cu_stall),
    .f_instr_i(f_instr), .f_current_pc_i(f_pc), .f_next_pc_i(f_npc), .f_valid_i(f_valid),
    .f_ready_o(p_ready), .d_valid_o(p_dvalid), .d_instr_o(p_instr),
    .d_current_pc_o(p_pc), .d_next_pc_o(p_npc), .d_prediction_o(p_pred),
    .pred_redirect_o(p_redir), .pred_target_o(p_target), .level_o(p_level));

  rv_predecode_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .PREDICT_MODE(0)) inst_n (
    .clk_i(clk), .arstn_i(arstn), .cu_kill_i(cu_kill), .cu_stall_i(cu_stall),
    .f_instr_i(f_instr), .f_current_pc_i(f_pc), .f_next_pc_i(f_npc), .f_valid_i(f_valid),
    .f_ready_o(n_ready), .d_valid_o(n_dvalid), .d_instr_o(n_instr),
    .d_current_pc_o(n_pc), .d_next_pc_o(n_npc), .d_prediction_o(n_pred),
    .pred_redirect_o(n_redir), .pred_target_o(n_target), .level_o(n_level));

  // ---------------- scoreboard ----------------
  logic [ILEN-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [ILEN-1:0] ins, input logic [XLEN-1:0] pc);
    f_valid = 1'b1;
    f_instr = ins;
    f_pc    = pc;
    f_npc   = pc + 32'd4;
  endtask

  task automatic idle();
    f_valid = 1'b0;
  endtask

  task automatic kill_all();
    idle();
    cu_kill = 1'b1;
    tick();
    cu_kill = 1'b0;
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  // addi x0, x0, k : a non-control-flow filler instruction
  function automatic logic [31:0] nop_k(input int k);
    return 32'h0000_0013 | (32'(k) << 20);
  endfunction

  logic [31:0] ins_beq, ins_bne, ins_jalr, ins_jal;

  initial begin
    cu_kill = 1'b0; cu_stall = 1'b0; f_valid = 1'b0;
    f_instr = '0; f_pc = '0; f_npc = '0;
    ins_beq  = enc_b(13'h1FF8, 3'b000);          // imm_b = -8
    ins_bne  = enc_b(13'h0010, 3'b001);          // imm_b = +16
    ins_jalr = {12'd0, 5'd1, 3'd0, 5'd0, 7'b1100111};
    ins_jal  = enc_j(21'h00040);                 // imm_j = +0x40

    repeat (2) @(posedge clk);
    #1;
    // ---- reset state ----
    check("rst_level",  64'(p_level), 64'd0);
    check("rst_ready",  64'(p_ready), 64'd1);
    check("rst_dvalid", 64'(p_dvalid), 64'd0);
    check("rst_redir",  64'(p_redir), 64'd0);
    check("rst_target", 64'(p_target), 64'd0);
    arstn = 1'b1;
    tick();

    // ---- fill with decode stalled: 6 offers, 4 accepted ----
    cu_stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      offer(nop_k(k), 32'h1000 + 32'(4*k));
      check("fill_ready", 64'(p_ready), (k < 4) ? 64'd1 : 64'd0);
      if (k < 4) exp_q.push_back(nop_k(k));
      tick();
      check("fill_level", 64'(p_level), (k < 3) ? 64'(k+1) : 64'd4);
    end
    check("full_ready", 64'(p_ready), 64'd0);
    idle();
    cu_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("drain_level", 64'(p_level), 64'(4-k));
      check("drain_valid", 64'(p_dvalid), 64'd1);
      check("drain_instr", 64'(p_instr), 64'(exp_q.pop_front()));
      tick();
    end
    check("empty_level", 64'(p_level), 64'd0);
    check("empty_valid", 64'(p_dvalid), 64'd0);

    // ---- backward beq: redirect, wrong-path offer dropped ----
    cu_stall = 1'b1;
    offer(ins_beq, 32'h100);
    tick();
    check("beq_redir",    64'(p_redir), 64'd1);
    check("beq_target",   64'(p_target), 64'h0F8);
    check("beq_level",    64'(p_level), 64'd1);
    check("nopred_redir", 64'(n_redir), 64'd0);
    check("nopred_pred",  64'(n_pred), 64'd0);
    offer(nop_k(7), 32'h104);
    tick();
    check("drop_redir",  64'(p_redir), 64'd0);
    check("drop_level",  64'(p_level), 64'd1);
    check("beq_pred",    64'(p_pred), 64'd1);
    check("beq_instr",   64'(p_instr), 64'(ins_beq));
    check("beq_pc",      64'(p_pc), 64'h100);
    check("beq_npc",     64'(p_npc), 64'h104);
    check("nopred_redir2", 64'(n_redir), 64'd0);
    kill_all();

    // ---- forward bne, jalr, jal; then kill at level 3 with everything active ----
    cu_stall = 1'b1;
    offer(ins_bne, 32'h300);
    tick();
    check("bne_redir", 64'(p_redir), 64'd0);
    check("bne_pred",  64'(p_pred), 64'd0);
    check("bne_level", 64'(p_level), 64'd1);
    offer(ins_jalr, 32'h304);
    tick();
    check("jalr_redir", 64'(p_redir), 64'd0);
    check("jalr_level", 64'(p_level), 64'd2);
    offer(ins_jal, 32'h200);
    tick();
    check("jal_redir",  64'(p_redir), 64'd1);
    check("jal_target", 64'(p_target), 64'h240);
    check("jal_level",  64'(p_level), 64'd3);
    offer(nop_k(9), 32'h400);
    cu_stall = 1'b0;
    cu_kill  = 1'b1;
    tick();
    cu_kill = 1'b0;
    check("kill_level", 64'(p_level), 64'd0);
    check("kill_valid", 64'(p_dvalid), 64'd0);
    check("kill_redir", 64'(p_redir), 64'd0);
    check("kill_ready", 64'(p_ready), 64'd1);
    idle();
    tick();
    check("kill_hold", 64'(p_level), 64'd0);

    // ---- continuous push+pop at level 2 across pointer wrap ----
    cu_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      offer(nop_k(20+k), 32'h2000 + 32'(4*k));
      exp_q.push_back(nop_k(20+k));
      tick();
    end
    check("steady_start", 64'(p_level), 64'd2);
    cu_stall = 1'b0;
    for (int k = 2; k < 2 + 3*DEPTH; k++) begin
      check("steady_head", 64'(p_instr), 64'(exp_q.pop_front()));
      offer(nop_k(20+k), 32'h2000 + 32'(4*k));
      exp_q.push_back(nop_k(20+k));
      tick();
      check("steady_level", 64'(p_level), 64'd2);
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      check("steady_tail", 64'(p_instr), 64'(exp_q.pop_front()));
      tick();
    end
    check("steady_empty", 64'(p_level), 64'd0);

    // ---- asynchronous reset mid-operation ----
    cu_stall = 1'b1;
    offer(ins_jal, 32'h200);
    tick();
    idle();
    #2 arstn = 1'b0;
    #1;
    check("arst_level", 64'(p_level), 64'd0);
    check("arst_valid", 64'(p_dvalid), 64'd0);
    check("arst_redir", 64'(p_redir), 64'd0);
    check("arst_ready", 64'(p_ready), 64'd1);
    arstn = 1'b1;
    tick();

    // ---- final report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
